// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: definitions shared by the two-client RAM arbiter.
//   num_clients : number of requesting clients (fixed at 2)
//   state_t     : arbiter FSM states (INIT = zero-fill sweep, RUN = arbitrate)
package ram_arb_pkg;

    localparam int num_clients = 2;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/ram_arb_rr.sv
// ram_arb_rr: 2-way round-robin grant with a one-bit priority pointer.
// Ports:
//   clk_i, reset_i : clock, asynchronous active-high reset (pointer -> client 0)
//   en_i           : grant enable; no grant is issued while low
//   elig_i         : per-client eligibility
//   gnt_o          : one-hot grant, or zero
module ram_arb_rr
    import ram_arb_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   en_i,
    input  logic [num_clients-1:0] elig_i,
    output logic [num_clients-1:0] gnt_o
);

    logic ptr_q;

    always_comb begin
        gnt_o = '0;
        if (en_i) begin
            if (elig_i[ptr_q]) begin
                gnt_o[ptr_q] = 1'b1;
            end else if (elig_i[~ptr_q]) begin
                gnt_o[~ptr_q] = 1'b1;
            end
        end
    end

    // After a grant the client that was not served becomes favoured.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr_q <= 1'b0;
        end else if (|gnt_o) begin
            ptr_q <= ~gnt_o[1];
        end
    end

endmodule

// File: rtl/ram_arb.sv
// ram_arb: arbitrates two clients onto one RAM write port and one RAM read
// port, and holds one read-response slot per client.
// Optional feature: define RAM_ARB_INIT_EN to zero-fill the whole RAM after
// reset (busy_o high, requests held off) before arbitration starts.
// Ports:
//   clk_i, reset_i              : clock, asynchronous active-high reset
//   req_valid_i/req_ready_o     : per-client request handshake
//   req_we_i                    : per-client op (1 = write, 0 = read)
//   req_addr_i, req_data_i      : per-client address / write data (client k in slice k)
//   rsp_valid_o/rsp_ready_i     : per-client read-response handshake
//   rsp_data_o                  : per-client read data
//   ram_wr_valid_o/addr_o/data_o: RAM write port
//   ram_rd_valid_o/addr_o       : RAM read port
//   ram_rd_data_i               : registered RAM read data (cycle after ram_rd_valid_o)
//   busy_o                      : high while the init sweep runs
//
// state | meaning
// INIT  | writing zero to one address per cycle, no grants
// RUN   | round-robin arbitration of client requests
module ram_arb
    import ram_arb_pkg::*;
#(
    parameter int  width_p = 8,
    parameter int  depth_p = 512,
    localparam int aw      = $clog2(depth_p)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [num_clients-1:0]         req_valid_i,
    output logic [num_clients-1:0]         req_ready_o,
    input  logic [num_clients-1:0]         req_we_i,
    input  logic [num_clients*aw-1:0]      req_addr_i,
    input  logic [num_clients*width_p-1:0] req_data_i,
    output logic [num_clients-1:0]         rsp_valid_o,
    input  logic [num_clients-1:0]         rsp_ready_i,
    output logic [num_clients*width_p-1:0] rsp_data_o,
    output logic                           ram_wr_valid_o,
    output logic [aw-1:0]                  ram_wr_addr_o,
    output logic [width_p-1:0]             ram_wr_data_o,
    output logic                           ram_rd_valid_o,
    output logic [aw-1:0]                  ram_rd_addr_o,
    input  logic [width_p-1:0]             ram_rd_data_i,
    output logic                           busy_o
);

    state_t                   state_q;
    logic [aw-1:0]            init_addr;
    logic [num_clients-1:0]   elig;
    logic [num_clients-1:0]   gnt;
    logic [num_clients-1:0]   rd_pend_q;
    logic [num_clients-1:0]   slot_v_q;
    logic [width_p-1:0]       slot_d_q [num_clients];
    logic                     run;
    logic                     sel;
    logic                     gnt_wr;
    logic                     gnt_rd;
    logic [aw-1:0]            sel_addr;
    logic [width_p-1:0]       sel_data;

`ifdef RAM_ARB_INIT_EN
    state_t        state_d;
    logic [aw-1:0] init_addr_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= INIT;
            init_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT) begin
                init_addr_q <= init_addr_q + aw'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == INIT && init_addr_q == aw'(depth_p - 1)) begin
            state_d = RUN;
        end
    end

    assign init_addr = init_addr_q;
    assign busy_o    = (state_q == INIT);
`else
    assign state_q   = RUN;
    assign init_addr = '0;
    assign busy_o    = 1'b0;
`endif

    assign run = (state_q == RUN) && !reset_i;

    // A read may only be granted when its slot is free by the next edge and no
    // earlier read is still on its way into the slot; otherwise the arriving
    // word would overwrite a response the client has not taken yet.
    always_comb begin
        elig = '0;
        for (int k = 0; k < num_clients; k++) begin
            elig[k] = req_valid_i[k] &
                      (req_we_i[k] | (~rd_pend_q[k] & (~slot_v_q[k] | rsp_ready_i[k])));
        end
    end

    ram_arb_rr u_rr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (run),
        .elig_i  (elig),
        .gnt_o   (gnt)
    );

    assign req_ready_o = gnt;
    assign sel         = gnt[1];
    assign sel_addr    = sel ? req_addr_i[2*aw-1:aw] : req_addr_i[aw-1:0];
    assign sel_data    = sel ? req_data_i[2*width_p-1:width_p] : req_data_i[width_p-1:0];
    assign gnt_wr      = |(gnt & req_we_i);
    assign gnt_rd      = |(gnt & ~req_we_i);

    always_comb begin
        ram_wr_valid_o = gnt_wr;
        ram_wr_addr_o  = sel_addr;
        ram_wr_data_o  = sel_data;
        if (state_q == INIT && !reset_i) begin
            ram_wr_valid_o = 1'b1;
            ram_wr_addr_o  = init_addr;
            ram_wr_data_o  = '0;
        end
    end

    assign ram_rd_valid_o = gnt_rd;
    assign ram_rd_addr_o  = sel_addr;

    // rd_pend marks the cycle the RAM word is on ram_rd_data_i; a fill wins
    // over an accept on the same edge.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_pend_q <= '0;
            slot_v_q  <= '0;
            for (int k = 0; k < num_clients; k++) begin
                slot_d_q[k] <= '0;
            end
        end else begin
            rd_pend_q <= gnt & ~req_we_i;
            for (int k = 0; k < num_clients; k++) begin
                if (rd_pend_q[k]) begin
                    slot_v_q[k] <= 1'b1;
                    slot_d_q[k] <= ram_rd_data_i;
                end else if (rsp_ready_i[k]) begin
                    slot_v_q[k] <= 1'b0;
                end
            end
        end
    end

    assign rsp_valid_o = slot_v_q;
    assign rsp_data_o  = {slot_d_q[1], slot_d_q[0]};

endmodule

// File: tb/tb_ram_arb.sv
module tb_ram_arb;

`ifdef RAM_ARB_INIT_EN
    localparam int depth_c = 16;
    localparam bit init_c  = 1'b1;
`else
    localparam int depth_c = 512;
    localparam bit init_c  = 1'b0;
`endif
    localparam int width_c = 8;
    localparam int aw_c    = $clog2(depth_c);

    logic                   clk_i   = 1'b0;
    logic                   reset_i = 1'b1;
    logic [1:0]             req_valid_i = '0;
    logic [1:0]             req_ready_o;
    logic [1:0]             req_we_i = '0;
    logic [2*aw_c-1:0]      req_addr_i = '0;
    logic [2*width_c-1:0]   req_data_i = '0;
    logic [1:0]             rsp_valid_o;
    logic [1:0]             rsp_ready_i = '0;
    logic [2*width_c-1:0]   rsp_data_o;
    logic                   ram_wr_valid_o;
    logic [aw_c-1:0]        ram_wr_addr_o;
    logic [width_c-1:0]     ram_wr_data_o;
    logic                   ram_rd_valid_o;
    logic [aw_c-1:0]        ram_rd_addr_o;
    logic [width_c-1:0]     ram_rd_data_i = '0;
    logic                   busy_o;

    always #5 clk_i = ~clk_i;

    ram_arb #(.width_p(width_c), .depth_p(depth_c)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_addr_i     (req_addr_i),
        .req_data_i     (req_data_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_data_o     (rsp_data_o),
        .ram_wr_valid_o (ram_wr_valid_o),
        .ram_wr_addr_o  (ram_wr_addr_o),
        .ram_wr_data_o  (ram_wr_data_o),
        .ram_rd_valid_o (ram_rd_valid_o),
        .ram_rd_addr_o  (ram_rd_addr_o),
        .ram_rd_data_i  (ram_rd_data_i),
        .busy_o         (busy_o)
    );

    // Synchronous RAM attached to the DUT ports.
    logic [width_c-1:0] ram [depth_c];
    always @(posedge clk_i) begin
        if (ram_wr_valid_o) ram[ram_wr_addr_o] <= ram_wr_data_o;
        if (ram_rd_valid_o) ram_rd_data_i <= ram[ram_rd_addr_o];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: favoured client, per-client response slot, per-client
    // read in flight (returns two cycles after grant), and a memory image.
    int                 fav;
    bit                 m_slot_v [2];
    logic [width_c-1:0] m_slot_d [2];
    bit                 m_infl   [2];
    logic [width_c-1:0] m_infl_d [2];
    logic [width_c-1:0] ref_mem  [depth_c];
    bit                 init_active;
    int                 init_idx;

    task automatic model_step();
        bit [1:0]           el;
        int                 g;
        int                 a;
        logic [width_c-1:0] d;
        bit                 is_wr;
        for (int k = 0; k < 2; k++) begin
            el[k] = req_valid_i[k] &&
                    (req_we_i[k] || (!m_infl[k] && (!m_slot_v[k] || rsp_ready_i[k])));
        end
        g = -1;
        if (el[fav]) g = fav;
        else if (el[1-fav]) g = 1 - fav;
        a = 0; d = '0; is_wr = 1'b0;
        if (g >= 0) begin
            a     = int'(req_addr_i[g*aw_c +: aw_c]);
            d     = req_data_i[g*width_c +: width_c];
            is_wr = req_we_i[g];
        end
        check("req_ready", 32'(req_ready_o), (g < 0) ? 32'd0 : 32'(1 << g));
        check("busy", 32'(busy_o), 32'd0);
        check("wr_valid", 32'(ram_wr_valid_o), 32'(g >= 0 && is_wr));
        check("rd_valid", 32'(ram_rd_valid_o), 32'(g >= 0 && !is_wr));
        if (g >= 0 && is_wr) begin
            check("wr_addr", 32'(ram_wr_addr_o), 32'(a));
            check("wr_data", 32'(ram_wr_data_o), 32'(d));
        end
        if (g >= 0 && !is_wr) check("rd_addr", 32'(ram_rd_addr_o), 32'(a));
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rsp_valid%0d", k), 32'(rsp_valid_o[k]), 32'(m_slot_v[k]));
            if (m_slot_v[k])
                check($sformatf("rsp_data%0d", k), 32'(rsp_data_o[k*width_c +: width_c]), 32'(m_slot_d[k]));
        end
        for (int k = 0; k < 2; k++) begin
            if (m_slot_v[k] && rsp_ready_i[k]) m_slot_v[k] = 1'b0;
            if (m_infl[k]) begin
                m_slot_v[k] = 1'b1;
                m_slot_d[k] = m_infl_d[k];
                m_infl[k]   = 1'b0;
            end
        end
        if (g >= 0) begin
            if (is_wr) ref_mem[a] = d;
            else begin
                m_infl[g]   = 1'b1;
                m_infl_d[g] = ref_mem[a];
            end
            fav = 1 - g;
        end
    endtask

    always @(negedge clk_i) begin
        if (reset_i) begin
            check("rst_req_ready", 32'(req_ready_o), 32'd0);
            check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
            check("rst_rsp_data", 32'(rsp_data_o), 32'd0);
            fav         = 0;
            m_slot_v    = '{1'b0, 1'b0};
            m_infl      = '{1'b0, 1'b0};
            init_active = init_c;
            init_idx    = 0;
        end else if (init_active) begin
            check("init_busy", 32'(busy_o), 32'd1);
            check("init_req_ready", 32'(req_ready_o), 32'd0);
            check("init_wr_valid", 32'(ram_wr_valid_o), 32'd1);
            check("init_wr_addr", 32'(ram_wr_addr_o), 32'(init_idx));
            check("init_wr_data", 32'(ram_wr_data_o), 32'd0);
            ref_mem[init_idx] = '0;
            init_idx++;
            if (init_idx == depth_c) init_active = 1'b0;
        end else begin
            model_step();
        end
    end

    task automatic cyc(input logic [1:0] v, input logic [1:0] we, input logic [1:0] rr,
                       input int a0, input int a1, input int d0, input int d1);
        req_valid_i = v;
        req_we_i    = we;
        rsp_ready_i = rr;
        req_addr_i  = {aw_c'(a1), aw_c'(a0)};
        req_data_i  = {width_c'(d1), width_c'(d0)};
        @(posedge clk_i);
        #1;
    endtask

    task automatic release_reset();
        reset_i = 1'b0;
        repeat (init_c ? depth_c : 0) @(posedge clk_i);
        #1;
    endtask

    initial begin
        for (int i = 0; i < depth_c; i++) begin
            ram[i]     = '0;
            ref_mem[i] = '0;
        end
        // Requests present while reset is held must not be granted.
        cyc(2'b11, 2'b11, 2'b11, 1, 2, 3, 4);
        cyc(2'b11, 2'b00, 2'b11, 1, 2, 3, 4);
        cyc(2'b00, 2'b00, 2'b11, 0, 0, 0, 0);
        release_reset();

        // Simultaneous writes: client 0 first, client 1 next cycle.
        cyc(2'b11, 2'b11, 2'b11, 5, 6, 'hAA, 'hBB);
        cyc(2'b10, 2'b11, 2'b11, 5, 6, 'hAA, 'hBB);
        cyc(2'b00, 2'b00, 2'b11, 0, 0, 0, 0);
        check("ram5", 32'(ram[5]), 32'hAA);
        check("ram6", 32'(ram[6]), 32'hBB);

        // Read right after write to the same address.
        cyc(2'b01, 2'b01, 2'b11, 5, 0, 'h5A, 0);
        cyc(2'b01, 2'b00, 2'b11, 5, 0, 0, 0);
        cyc(2'b01, 2'b01, 2'b11, 5, 0, 'hAA, 0);
        cyc(2'b01, 2'b00, 2'b11, 5, 0, 0, 0);
        repeat (3) cyc(2'b00, 2'b00, 2'b11, 0, 0, 0, 0);

        // Both clients continuously valid: grants alternate.
        for (int i = 0; i < 10; i++)
            cyc(2'b11, 2'b11, 2'b11, $urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 255), $urandom_range(0, 255));

        // Client 1 holds its full slot; client 0 keeps reading.
        cyc(2'b10, 2'b00, 2'b01, 0, 6, 0, 0);
        for (int i = 0; i < 8; i++)
            cyc(2'b11, 2'b00, 2'b01, $urandom_range(0, 15), 9, 0, 0);
        repeat (3) cyc(2'b00, 2'b00, 2'b11, 0, 0, 0, 0);

        // Randomized traffic over a small address range.
        for (int i = 0; i < 400; i++)
            cyc(2'($urandom), 2'($urandom),
                {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)},
                $urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 255), $urandom_range(0, 255));
        repeat (3) cyc(2'b00, 2'b00, 2'b11, 0, 0, 0, 0);

        // Reset with a read in flight: no stale response afterwards.
        cyc(2'b01, 2'b00, 2'b11, 5, 0, 0, 0);
        req_valid_i = 2'b00;
        reset_i     = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        release_reset();
        repeat (4) cyc(2'b00, 2'b00, 2'b11, 0, 0, 0, 0);
        cyc(2'b01, 2'b00, 2'b11, 6, 0, 0, 0);
        repeat (4) cyc(2'b00, 2'b00, 2'b11, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_arb.md
RAM_ARB -- requirements
Module: ram_arb

Interface
REQ-001 Parameter width_p, default 8: RAM word width in bits.
REQ-002 Parameter depth_p, default 512: RAM depth in words; address width aw = $clog2(depth_p).
REQ-003 clk_i  in  1  single clock for all logic.
REQ-004 reset_i  in  1  asynchronous, active-high reset.
REQ-005 req_valid_i  in  2  per-client request valid; bit k = client k.
REQ-006 req_ready_o  out  2  per-client request ready; a request transfers when valid and ready are both high.
REQ-007 req_we_i  in  2  per-client op: 1 = write, 0 = read.
REQ-008 req_addr_i  in  2*aw  per-client address, client k in slice k.
REQ-009 req_data_i  in  2*width_p  per-client write data.
REQ-010 rsp_valid_o  out  2  per-client read response valid.
REQ-011 rsp_ready_i  in  2  per-client response accept.
REQ-012 rsp_data_o  out  2*width_p  per-client read data.
REQ-013 ram_wr_valid_o, ram_wr_addr_o, ram_wr_data_o  out  1/aw/width_p  RAM write port.
REQ-014 ram_rd_valid_o, ram_rd_addr_o  out  1/aw  RAM read port; ram_rd_data_i  in  width_p  registered RAM read data, valid the cycle after ram_rd_valid_o.
REQ-015 busy_o  out  1  high while init sweep runs.

Function
REQ-016 At most one request SHALL be granted per cycle; req_ready_o SHALL be one-hot or zero.
REQ-017 Client k is eligible if req_valid_i[k] and (write, or its response slot is empty, or the slot is accepted this cycle).
REQ-018 Arbitration SHALL be round-robin: priority pointer selects the favoured client; after any grant the pointer moves to the other client; no grant, no move.
REQ-019 A granted write SHALL drive ram_wr_valid_o=1 with the client's addr/data in the same cycle, combinationally.
REQ-020 A granted read SHALL drive ram_rd_valid_o=1 with the client's addr in the same cycle; the RAM word is captured into client k's response slot at the next edge; rsp_valid_o[k] rises 2 cycles after the grant edge.
REQ-021 The response slot SHALL hold data and valid stable until rsp_ready_i[k]; it clears on accept unless refilled the same edge.
REQ-022 Read-after-write: a read granted the cycle after a write to the same address SHALL return the new data.
REQ-023 A blocked client (slot full) SHALL NOT stall the other client.
REQ-024 With no grant, ram_wr_valid_o and ram_rd_valid_o SHALL be 0.

Reset
REQ-025 On reset_i: pointer = client 0; both response slots empty; rsp_valid_o=0, rsp_data_o=0; in-flight reads are dropped.
REQ-026 req_ready_o SHALL be 0 while reset_i is high.

Configuration
REQ-027 Macro RAM_ARB_INIT_EN defined: after reset the FSM enters INIT, writes 0 to addresses 0..depth_p-1 one per cycle, busy_o=1, req_ready_o=0; after address depth_p-1 it moves to RUN; reset mid-sweep restarts at 0.
REQ-028 Macro undefined: FSM starts in RUN, busy_o tied 0, no init writes.

Structure
REQ-029 Shared package ram_arb_pkg SHALL hold the FSM state enum (INIT, RUN) and the client-count constant (2).
REQ-030 Sub-module ram_arb_rr (2-way round-robin grant with pointer) is natural; the response slots remain in ram_arb.

Verification
REQ-031 Both clients write at once, client0 addr 5 data 0xAA, client1 addr 6 data 0xBB -> client0 granted first, client1 next cycle, RAM gets both.
REQ-032 Client0 reads addr 5 right after its write of 0xAA -> rsp_valid_o[0] 2 cycles after grant, data 0xAA.
REQ-033 Client1 holds rsp_ready_i=0 with slot full and issues a read -> req_ready_o[1]=0; client0 reads still granted every other/free cycle.
REQ-034 Both clients continuously valid for 10 cycles -> grants strictly alternate 0,1,0,1...
REQ-035 Assert reset_i while a read is in flight -> rsp_valid_o=0 after reset, no stale response appears.
REQ-036 With RAM_ARB_INIT_EN, depth_p=16 -> busy_o high 16 cycles, addresses 0..15 written 0, then requests are granted.
